// File: rtl/cabin_status_pkg.sv
// Shared FSM encoding, frame geometry and payload field layout for cabin_status_tx.
// Frame length depends on STATUS_TX_PARITY_EN.
package cabin_status_pkg;

  typedef enum logic [2:0] {IDLE, START, SEQ, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned SEQ_BITS     = 4;
  localparam int unsigned PAYLOAD_BITS = 10;

  localparam int unsigned OFF_SEATBELT = 0;
  localparam int unsigned OFF_LIGHTING = 1;
  localparam int unsigned OFF_LOCKED   = 3;
  localparam int unsigned OFF_FAULT    = 4;
  localparam int unsigned OFF_PHASE    = 5;
  localparam int unsigned OFF_DEBUG    = 6;

`ifdef STATUS_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif
  // start + seq + payload + optional parity + stop
  localparam int unsigned FRAME_BITS = 2 + SEQ_BITS + PAYLOAD_BITS + PARITY_BITS;

  function automatic logic [PAYLOAD_BITS-1:0] pack_payload(
    input logic       seatbelt_on,
    input logic [1:0] lighting_mode,
    input logic       system_locked,
    input logic       fault_alert,
    input logic       phase_stable,
    input logic [3:0] state_debug
  );
    logic [PAYLOAD_BITS-1:0] p;
    p = '0;
    p[OFF_SEATBELT]      = seatbelt_on;
    p[OFF_LIGHTING +: 2] = lighting_mode;
    p[OFF_LOCKED]        = system_locked;
    p[OFF_FAULT]         = fault_alert;
    p[OFF_PHASE]         = phase_stable;
    p[OFF_DEBUG +: 4]    = state_debug;
    return p;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit cycle counter for cabin_status_tx: strobes on the last and the
// second-to-last cycle of each serial bit while the transmitter is busy.
module tx_bit_timer #(
  parameter int unsigned BIT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_done,
  output logic bit_pre_done
);
  localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(BIT_CYCLES - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= bit_done ? '0 : cnt + 1'b1;
  end

  always_comb begin
    bit_done     = run && (cnt == LAST);
    bit_pre_done = run && (cnt == PRE);
  end

endmodule

// File: rtl/cabin_status_tx.sv
// Serial cabin status transmitter: sends on change, on heartbeat expiry, or after reset.
// Define STATUS_TX_PARITY_EN to append an even-parity bit before STOP.
module cabin_status_tx
  import cabin_status_pkg::*;
#(
  parameter int unsigned BIT_CYCLES       = 8,
  parameter int unsigned HEARTBEAT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       seatbelt_on,
  input  logic [1:0] lighting_mode,
  input  logic       system_locked,
  input  logic       fault_alert,
  input  logic       phase_stable,
  input  logic [3:0] state_debug,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       frame_sent,
  output logic [3:0] seq_num
);
  localparam int unsigned HBW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HBW-1:0] HB_MAX = HBW'(HEARTBEAT_CYCLES - 1);
  localparam int unsigned SR_BITS = FRAME_BITS - 2;

  tx_state_t               state;
  logic [PAYLOAD_BITS-1:0] payload, snapshot;
  logic [SEQ_BITS-1:0]     seq_next;
  logic [SR_BITS-1:0]      sr, frame_load;
  logic [3:0]              bit_idx;
  logic [HBW-1:0]          hb_cnt;
  logic                    first_pending, launch, bit_done, bit_pre_done;

  always_comb begin
    payload  = pack_payload(seatbelt_on, lighting_mode, system_locked,
                            fault_alert, phase_stable, state_debug);
    seq_next = seq_num + 1'b1;
    launch   = (state == IDLE) && en &&
               ((payload != snapshot) || (hb_cnt == HB_MAX) || first_pending);
`ifdef STATUS_TX_PARITY_EN
    frame_load = {^{seq_next, payload}, payload, seq_next};
`else
    frame_load = {payload, seq_next};
`endif
  end

  tx_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .clear        (launch),
    .run          (tx_busy),
    .bit_done     (bit_done),
    .bit_pre_done (bit_pre_done)
  );

  // sr holds every bit after START, LSB next; each bit_done moves sr[0] onto the line
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tx_line       <= 1'b1;
      tx_busy       <= 1'b0;
      frame_sent    <= 1'b0;
      seq_num       <= 4'hF;
      bit_idx       <= '0;
      hb_cnt        <= '0;
      snapshot      <= '0;
      first_pending <= 1'b1;
      sr            <= '0;
    end else begin
      frame_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state         <= START;
            tx_line       <= 1'b0;
            tx_busy       <= 1'b1;
            snapshot      <= payload;
            seq_num       <= seq_next;
            first_pending <= 1'b0;
            hb_cnt        <= '0;
            sr            <= frame_load;
          end else if (en && (hb_cnt != HB_MAX)) begin
            hb_cnt <= hb_cnt + 1'b1;
          end
        end
        START: if (bit_done) begin
          state   <= SEQ;
          bit_idx <= '0;
          tx_line <= sr[0];
          sr      <= sr >> 1;
        end
        SEQ: if (bit_done) begin
          tx_line <= sr[0];
          sr      <= sr >> 1;
          if (bit_idx == 4'(SEQ_BITS - 1)) begin
            state   <= DATA;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        DATA: if (bit_done) begin
          if (bit_idx == 4'(PAYLOAD_BITS - 1)) begin
`ifdef STATUS_TX_PARITY_EN
            state   <= PARITY;
            tx_line <= sr[0];
`else
            state   <= STOP;
            tx_line <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx_line <= sr[0];
            sr      <= sr >> 1;
          end
        end
        PARITY: if (bit_done) begin
          state   <= STOP;
          tx_line <= 1'b1;
        end
        STOP: begin
          if (bit_pre_done) frame_sent <= 1'b1;
          if (bit_done) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cabin_status_tx.md
CABIN_STATUS_TX -- requirements
Module: cabin_status_tx

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 8, clock cycles per serial bit (min 2).
REQ-002 SHALL have parameter HEARTBEAT_CYCLES, default 1000, idle cycles before a forced refresh frame.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  transmit enable, low during maintenance freeze.
REQ-006 SHALL have ports seatbelt_on (1), lighting_mode (2), system_locked (1), fault_alert (1), phase_stable (1), state_debug (4), all inputs, carrying the cabin controller status.
REQ-007 SHALL have port tx_line  output  1  serial status line, idle high.
REQ-008 SHALL have port tx_busy  output  1  high from START through STOP.
REQ-009 SHALL have port frame_sent  output  1  one-cycle pulse at frame end.
REQ-010 SHALL have port seq_num  output  4  sequence number of the last launched frame.

Function
REQ-011 Payload SHALL be 10 bits, {state_debug, phase_stable, fault_alert, system_locked, lighting_mode, seatbelt_on}, with seatbelt_on at bit 0.
REQ-012 Frame SHALL be a start bit (0), then seq_num as 4 bits LSB first, then the payload as 10 bits LSB first, then a stop bit (1): 16 bits. Every bit SHALL be held for exactly BIT_CYCLES cycles.
REQ-013 FSM states SHALL be IDLE, START, SEQ, DATA, PARITY, STOP. Transitions: IDLE->START on launch; START->SEQ; SEQ->DATA after 4 bits; DATA->PARITY (macro on) or DATA->STOP after 10 bits; PARITY->STOP; STOP->IDLE.
REQ-014 Launch condition in IDLE with en=1: live payload != last-sent snapshot, OR the heartbeat counter has reached HEARTBEAT_CYCLES-1, OR first_pending=1.
REQ-015 On the launch edge: state becomes START, tx_line goes 0, the payload snapshot is captured, seq_num increments (wraps 15->0), and first_pending clears.
REQ-016 Latency SHALL be 1 cycle: a condition true at edge N SHALL put tx_line=0 after edge N+1.
REQ-017 Input changes during a frame SHALL NOT alter the frame in flight. Because comparison is against the snapshot, a pending difference SHALL launch on the first IDLE cycle evaluation, giving a minimum of 1 idle-high cycle between frames.
REQ-018 The heartbeat counter SHALL count only in IDLE with en=1, clear on launch, and saturate at HEARTBEAT_CYCLES-1.
REQ-019 A heartbeat expiry and a payload change in the same cycle SHALL produce exactly one frame.
REQ-020 frame_sent SHALL pulse on the last cycle of STOP, and tx_busy SHALL fall on the following edge.
REQ-021 If en=0 mid-frame, the frame SHALL complete unaltered. With en=0 in IDLE: no launch, heartbeat frozen, snapshot retained.

Reset
REQ-022 Reset SHALL force, on the next edge: tx_line=1, tx_busy=0, frame_sent=0, seq_num=4'hF (first frame carries 0), state=IDLE, bit timer=0, heartbeat=0, snapshot=0, first_pending=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no frame_sent pulse, and tx_line SHALL be high after that edge.

Configuration
REQ-024 Macro STATUS_TX_PARITY_EN defined: insert an even-parity bit (XOR of seq_num and payload) between DATA and STOP, making the frame 17 bits. Undefined: no PARITY state is reachable, and the frame is 16 bits.

Structure
REQ-025 Shared package cabin_status_pkg SHALL hold: the FSM state encoding; the SEQ_BITS=4 and PAYLOAD_BITS=10 constants; the payload field offsets; the frame-length constants.
REQ-026 Sub-module tx_bit_timer SHALL count BIT_CYCLES per bit and emit a bit_done strobe. It SHALL be cleared on launch and on reset.

Verification (BIT_CYCLES=4, HEARTBEAT_CYCLES=100)
REQ-027 Reset released with seatbelt_on=1, lighting_mode=01, rest 0 -> tx_line low 1 cycle later; seq=0; payload 10'b0000000011; frame_sent 64 cycles after start.
REQ-028 lighting_mode 01->10 mid-frame -> current frame unchanged; next frame starts 1 cycle after frame_sent with seq=1 and payload bits[2:1]=10.
REQ-029 Static inputs -> refresh frame launches after 100 idle cycles, with seq incrementing and payload identical; a change coinciding with expiry -> one frame only.
REQ-030 en dropped at DATA bit 3 -> frame completes; no frames while en=0 over 500 cycles; en restored with a changed payload -> frame starts 1 cycle later.
REQ-031 Reset pulsed at DATA bit 5 -> tx_line=1 and tx_busy=0 next cycle, no frame_sent; the next frame carries seq=0.
REQ-032 STATUS_TX_PARITY_EN, seq=1, payload 10'b0000000011 -> parity bit 1, frame 68 cycles.
